// File: rtl/vline_motion_pkg.sv
// Shared types and defaults for the vertical-line mover, its controller
// and the renderer.
package vline_motion_pkg;

  localparam int COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  localparam coord_t Y_MIN_DEF   = 16'd18;
  localparam coord_t Y_MAX_DEF   = 16'd487;
  localparam coord_t Y_START_DEF = 16'd240;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN
  } state_t;

endpackage

// File: rtl/vline_step_div.sv
// Frame-tick divider for the line controller: counts ticks, queues owed
// steps and spaces command pulses at least one idle cycle apart.
module vline_step_div
  #(
    parameter logic [3:0] STEP_DIV = 4'd1
  )
  (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    input  logic frame_tick,
    input  logic take,
    input  logic pulse,
    output logic due,
    output logic busy
  );

  localparam logic [3:0] LAST =
    (STEP_DIV == 4'd0) ? 4'd0 : STEP_DIV - 4'd1;

  logic [3:0] div;
  logic [3:0] pend;
  logic       wrap;

  assign wrap = en & frame_tick & (div == LAST);
  assign due  = en & ~busy & (pend != 4'd0);

  // Tick counter: advances on each enabled tick, wraps on the final count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 4'd0;
    end else if (clr) begin
      div <= 4'd0;
    end else if (en && frame_tick) begin
      div <= (div == LAST) ? 4'd0 : div + 4'd1;
    end
  end

  // Owed steps: a wrap adds one, an issued step removes one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend <= 4'd0;
    end else if (clr) begin
      pend <= 4'd0;
    end else begin
      unique case ({wrap, take})
        2'b10: if (pend != 4'hF) pend <= pend + 4'd1;
        2'b01: pend <= pend - 4'd1;
        default: ;
      endcase
    end
  end

  // Guard cycle after any command so pulses never merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
    end else begin
      busy <= pulse;
    end
  end

endmodule

// File: rtl/vline_motion_ctrl.sv
// Command-side initiator for the vertical-line mover: issues UP/DW/LD
// pulses so the line bounces between Y_MIN and Y_MAX once per step.
module vline_motion_ctrl
  import vline_motion_pkg::*;
  #(
    parameter coord_t     Y_MIN    = Y_MIN_DEF,
    parameter coord_t     Y_MAX    = Y_MAX_DEF,
    parameter coord_t     Y_START  = Y_START_DEF,
    parameter logic [3:0] STEP_DIV = 4'd1
  )
  (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               go,
    input  logic               stop,
    input  logic               pause,
    input  logic [COORD_W-1:0] ycoord,
    output logic               UP,
    output logic               DW,
    output logic               LD,
    output logic [COORD_W-1:0] ld_value,
    output logic               dir,
    output logic               running,
    output logic [7:0]         bounce_cnt
  );

  state_t state;
  logic   go_q;
  logic   go_rise;
  logic   in_run;
  logic   relaunch;
  logic   fire;
  logic   due;
  logic   busy;
  logic   step_up;
  logic   flip;

  assign ld_value = Y_START;

  assign go_rise  = go & ~go_q;
  assign in_run   = (state == RUN);
  assign relaunch = go & ~stop &
                    ((state == IDLE) | (in_run & go_rise));
  assign fire     = due & in_run & ~stop & ~go_rise;

  // At a bound the direction flips and the step heads back inward.
  assign flip    = dir ? (ycoord >= Y_MAX) : (ycoord <= Y_MIN);
  assign step_up = dir ^ flip;

  vline_step_div #(
    .STEP_DIV (STEP_DIV)
  ) u_div (
    .clk        (clk),
    .reset      (reset),
    .en         (in_run & ~pause),
    .clr        (relaunch),
    .frame_tick (frame_tick),
    .take       (fire),
    .pulse      (relaunch | fire),
    .due        (due),
    .busy       (busy)
  );

  // Remember go so a held level restarts only once from RUN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_q <= 1'b0;
    end else begin
      go_q <= go;
    end
  end

  // Control FSM with registered command pulses and status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      UP         <= 1'b0;
      DW         <= 1'b0;
      LD         <= 1'b0;
      dir        <= 1'b1;
      running    <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      UP <= 1'b0;
      DW <= 1'b0;
      LD <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        running <= 1'b0;
      end else if (relaunch) begin
        state      <= LOAD;
        LD         <= 1'b1;
        dir        <= 1'b1;
        bounce_cnt <= 8'd0;
        running    <= 1'b1;
      end else begin
        unique case (state)
          LOAD: begin
            state   <= SETTLE;
            running <= 1'b0;
          end
          SETTLE: begin
            state   <= RUN;
            running <= 1'b1;
          end
          RUN: begin
            if (fire) begin
              UP <= step_up;
              DW <= ~step_up;
              if (flip) begin
                dir        <= ~dir;
                bounce_cnt <= bounce_cnt + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vline_motion_ctrl.sv
// Bench for vline_motion_ctrl: two instances (divide by 1 and by 3)
// driven together, each closing the loop through a mover model.
module tb_vline_motion_ctrl;

  localparam logic [15:0] YMIN = 16'd18;
  localparam logic [15:0] YMAX = 16'd487;

  logic clk = 1'b0;
  logic reset;
  logic frame_tick;
  logic go;
  logic stop;
  logic pause;

  logic        up  [2];
  logic        dw  [2];
  logic        ld  [2];
  logic        dr  [2];
  logic        run [2];
  logic [15:0] ldv [2];
  logic [7:0]  bc  [2];
  logic [15:0] my  [2] = '{16'd0, 16'd0};

  logic        pre_en = 1'b0;
  logic [15:0] pre_val = 16'd0;
  bit          pin = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vline_motion_ctrl u0 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .go(go), .stop(stop), .pause(pause), .ycoord(my[0]),
    .UP(up[0]), .DW(dw[0]), .LD(ld[0]), .ld_value(ldv[0]),
    .dir(dr[0]), .running(run[0]), .bounce_cnt(bc[0])
  );

  vline_motion_ctrl #(.STEP_DIV(4'd3)) u1 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .go(go), .stop(stop), .pause(pause), .ycoord(my[1]),
    .UP(up[1]), .DW(dw[1]), .LD(ld[1]), .ld_value(ldv[1]),
    .dir(dr[1]), .running(run[1]), .bounce_cnt(bc[1])
  );

  // Mover counter model; pin mode snaps to the bounds to force bounces.
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (pre_en) my[i] <= pre_val;
      else if (ld[i]) my[i] <= ldv[i];
      else if (up[i]) my[i] <= pin ? YMAX : my[i] + 16'd1;
      else if (dw[i]) my[i] <= pin ? YMIN : my[i] - 16'd1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Behavioural model: phase 0 off, 1 loading, 2 settling, 3 stepping.
  int ph[2], ticks[2], owed[2], quiet[2], e_bc[2];
  bit e_up[2], e_dw[2], e_ld[2], e_dir[2];
  bit g_prev;

  function automatic int divisor(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic model_edge(input int i);
    int  d;
    bit  relaunch;
    e_up[i] = 0;
    e_dw[i] = 0;
    e_ld[i] = 0;
    if (quiet[i] < 9) quiet[i]++;
    relaunch = go && (ph[i] == 0 || (ph[i] == 3 && !g_prev));
    if (stop) begin
      ph[i] = 0;
    end else if (relaunch) begin
      ph[i] = 1;
      e_ld[i] = 1;
      e_dir[i] = 1;
      e_bc[i] = 0;
      ticks[i] = 0;
      owed[i] = 0;
      quiet[i] = 0;
    end else if (ph[i] == 1 || ph[i] == 2) begin
      ph[i]++;
    end else if (ph[i] == 3 && !pause) begin
      if (owed[i] > 0 && quiet[i] >= 2) begin
        if (e_dir[i]) d = (my[i] < YMAX) ? 1 : -1;
        else d = (my[i] > YMIN) ? -1 : 1;
        if ((d > 0) != e_dir[i]) begin
          e_dir[i] = (d > 0);
          e_bc[i] = (e_bc[i] + 1) % 256;
        end
        if (d > 0) e_up[i] = 1;
        else e_dw[i] = 1;
        owed[i]--;
        quiet[i] = 0;
      end
      if (frame_tick) begin
        ticks[i]++;
        if (ticks[i] >= divisor(i)) begin
          ticks[i] = 0;
          owed[i]++;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      g_prev = 0;
      for (int i = 0; i < 2; i++) begin
        ph[i] = 0; ticks[i] = 0; owed[i] = 0; quiet[i] = 9;
        e_up[i] = 0; e_dw[i] = 0; e_ld[i] = 0;
        e_dir[i] = 1; e_bc[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_edge(i);
      g_prev = go;
    end
  end

  int cyc = 0;
  int npulse[2] = '{0, 0};
  int nup[2] = '{0, 0};
  int ndw[2] = '{0, 0};
  int nld[2] = '{0, 0};
  int last_pc = 0;
  int prev_pc = 0;

  // Compare every cycle on the falling edge, then tally pulses.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.UP", i), 32'(up[i]), 32'(e_up[i]));
      chk($sformatf("u%0d.DW", i), 32'(dw[i]), 32'(e_dw[i]));
      chk($sformatf("u%0d.LD", i), 32'(ld[i]), 32'(e_ld[i]));
      chk($sformatf("u%0d.dir", i), 32'(dr[i]), 32'(e_dir[i]));
      chk($sformatf("u%0d.running", i), 32'(run[i]),
          32'(ph[i] == 1 || ph[i] == 3));
      chk($sformatf("u%0d.bounce_cnt", i), 32'(bc[i]), e_bc[i]);
      chk($sformatf("u%0d.ld_value", i), 32'(ldv[i]), 32'd240);
    end
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (up[i] === 1'b1 || dw[i] === 1'b1) npulse[i]++;
      if (up[i] === 1'b1) nup[i]++;
      if (dw[i] === 1'b1) ndw[i]++;
      if (ld[i] === 1'b1) nld[i]++;
    end
    if (up[0] === 1'b1 || dw[0] === 1'b1) begin
      prev_pc = last_pc;
      last_pc = cyc;
    end
  end

  task automatic step_clk(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      step_clk();
      frame_tick = 1'b0;
      step_clk(2);
    end
  endtask

  task automatic preload(input logic [15:0] v);
    pre_val = v;
    pre_en = 1'b1;
    step_clk();
    pre_en = 1'b0;
  endtask

  task automatic launch();
    go = 1'b1;
    step_clk();
    go = 1'b0;
    step_clk(2);
  endtask

  int a0, a1, b0, l0;

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    go = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    step_clk(2);
    chk("reset.running", 32'(run[0]), 32'd0);
    chk("reset.dir", 32'(dr[0]), 32'd1);
    chk("reset.bounce_cnt", 32'(bc[0]), 32'd0);
    reset = 1'b0;
    step_clk();

    // go -> LD one cycle later, then ten single-divider steps upward
    go = 1'b1;
    step_clk();
    chk("go.LD", 32'(ld[0]), 32'd1);
    chk("go.ld_value", 32'(ldv[0]), 32'd240);
    go = 1'b0;
    step_clk(2);
    chk("load.ycoord", 32'(my[0]), 32'd240);
    a0 = nup[0];
    b0 = ndw[0];
    tick_n(10);
    step_clk(2);
    chk("run.up_count", 32'(nup[0] - a0), 32'd10);
    chk("run.dw_count", 32'(ndw[0] - b0), 32'd0);
    chk("run.ycoord", 32'(my[0]), 32'd250);

    // upper bound bounce
    preload(16'd486);
    tick_n(2);
    step_clk(2);
    chk("top.dir", 32'(dr[0]), 32'd0);
    chk("top.bounce_cnt", 32'(bc[0]), 32'd1);
    chk("top.ycoord", 32'(my[0]), 32'd486);

    // lower bound bounce
    preload(16'd19);
    tick_n(2);
    step_clk(2);
    chk("bot.dir", 32'(dr[0]), 32'd1);
    chk("bot.bounce_cnt", 32'(bc[0]), 32'd2);
    chk("bot.ycoord", 32'(my[0]), 32'd19);

    // back-to-back ticks: second step deferred by the guard cycle
    a0 = npulse[0];
    frame_tick = 1'b1;
    step_clk(2);
    frame_tick = 1'b0;
    step_clk(5);
    chk("b2b.pulses", 32'(npulse[0] - a0), 32'd2);
    chk("b2b.spacing", 32'(last_pc - prev_pc), 32'd2);

    // bounce counter wrap after 256 reversals
    launch();
    pin = 1'b1;
    tick_n(256);
    step_clk(2);
    chk("wrap.bc255", 32'(bc[0]), 32'd255);
    chk("wrap.model255", 32'(e_bc[0]), 32'd255);
    tick_n(1);
    step_clk(2);
    chk("wrap.bc0", 32'(bc[0]), 32'd0);
    pin = 1'b0;

    // divide-by-3 instance with pause
    launch();
    a1 = npulse[1];
    tick_n(9);
    step_clk(2);
    chk("div3.steps", 32'(npulse[1] - a1), 32'd3);
    tick_n(2);
    step_clk(2);
    pause = 1'b1;
    a0 = npulse[0];
    a1 = npulse[1];
    tick_n(2);
    step_clk(2);
    chk("pause.u1", 32'(npulse[1] - a1), 32'd0);
    chk("pause.u0", 32'(npulse[0] - a0), 32'd0);
    pause = 1'b0;
    step_clk();
    tick_n(1);
    step_clk(2);
    chk("resume.u1", 32'(npulse[1] - a1), 32'd1);

    // stop with go in RUN: idle, no commands
    a0 = npulse[0];
    l0 = nld[0];
    stop = 1'b1;
    go = 1'b1;
    step_clk(3);
    chk("stopgo.running", 32'(run[0]), 32'd0);
    chk("stopgo.pulses", 32'(npulse[0] - a0), 32'd0);
    chk("stopgo.ld", 32'(nld[0] - l0), 32'd0);
    stop = 1'b0;
    go = 1'b0;
    step_clk();

    // async reset while a DW pulse is out, with dir low
    launch();
    preload(16'd487);
    tick_n(1);
    step_clk(2);
    chk("pre.dir", 32'(dr[0]), 32'd0);
    frame_tick = 1'b1;
    step_clk();
    frame_tick = 1'b0;
    step_clk();
    chk("pre.DW", 32'(dw[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst.DW", 32'(dw[0]), 32'd0);
    chk("arst.UP", 32'(up[0]), 32'd0);
    chk("arst.dir", 32'(dr[0]), 32'd1);
    chk("arst.running", 32'(run[0]), 32'd0);
    chk("arst.bounce_cnt", 32'(bc[0]), 32'd0);
    step_clk();
    reset = 1'b0;
    l0 = nld[0];
    step_clk(3);
    chk("arst.noreload", 32'(nld[0] - l0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
